// File: rtl/ni_packetizer.sv
// ============================================================================
// Module      : ni_packetizer
// Description : Network-interface packetizer. Splits a 64-bit packet into
//               head/body/tail flits. Optional macro NI_PKT_SEQ_EN enables a
//               per-packet sequence number carried in the head flit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ni_packetizer #(
    parameter logic [3:0] SRC_ID = 4'h0,
    parameter int         DEST_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [DEST_W-1:0] pkt_dest,
    input  logic [63:0]       pkt_data,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [33:0]       flit_out,
    output logic              busy,
    output logic [15:0]       pkt_sent_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_BODY = 2'b00;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  dest_hold;
    logic [63:0] data_hold;
    logic [7:0]  seq_val;
    logic        accept;
    logic        tail_xfer;

    // Flit fields are decoded purely from state and holding registers, so
    // flit_out cannot change while the flit is being offered.
    always_comb begin
        state_nxt  = state;
        pkt_ready  = 1'b0;
        flit_valid = 1'b0;
        busy       = 1'b0;
        flit_out   = 34'd0;
        accept     = 1'b0;
        tail_xfer  = 1'b0;
        case (state)
            IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    accept    = 1'b1;
                    state_nxt = HEAD;
                end
            end
            HEAD: begin
                busy       = 1'b1;
                flit_valid = ~mode;
                flit_out   = {TYPE_HEAD, 4'h0, SRC_ID, dest_hold, seq_val, 8'h00};
                if (!mode && flit_ready) begin
                    state_nxt = BODY;
                end
            end
            BODY: begin
                busy       = 1'b1;
                flit_valid = ~mode;
                flit_out   = {TYPE_BODY, data_hold[63:32]};
                if (!mode && flit_ready) begin
                    state_nxt = TAIL;
                end
            end
            TAIL: begin
                busy       = 1'b1;
                flit_valid = ~mode;
                flit_out   = {TYPE_TAIL, data_hold[31:0]};
                if (!mode && flit_ready) begin
                    tail_xfer = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            dest_hold    <= 8'd0;
            data_hold    <= 64'd0;
            pkt_sent_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dest_hold <= 8'(pkt_dest);
                data_hold <= pkt_data;
            end
            if (tail_xfer && (pkt_sent_cnt != 16'hFFFF)) begin
                pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
            end
        end
    end

`ifdef NI_PKT_SEQ_EN
    // Head carries the value held before the tail that follows it increments.
    logic [7:0] seq;

    always_ff @(posedge clk) begin
        if (!reset) begin
            seq <= 8'd0;
        end else if (tail_xfer) begin
            seq <= seq + 8'd1;
        end
    end

    assign seq_val = seq;
`else
    assign seq_val = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ni_packetizer.sv
// ============================================================================
// Module      : tb_ni_packetizer
// Description : Self-checking bench for ni_packetizer (SRC_ID = 2, DEST_W = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ni_packetizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [3:0]  pkt_dest;
    logic [63:0] pkt_data;
    logic        flit_valid;
    logic        flit_ready;
    logic [33:0] flit_out;
    logic        busy;
    logic [15:0] pkt_sent_cnt;

    int total = 0;
    int passed = 0;

    ni_packetizer #(
        .SRC_ID (4'h2),
        .DEST_W (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_dest     (pkt_dest),
        .pkt_data     (pkt_data),
        .flit_valid   (flit_valid),
        .flit_ready   (flit_ready),
        .flit_out     (flit_out),
        .busy         (busy),
        .pkt_sent_cnt (pkt_sent_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic        pv;
        logic [3:0]  dest;
        logic [63:0] data;
        logic        fr;
        logic        e_fv;
        logic [33:0] e_fo;
        logic        e_prdy;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic add(input logic m, input logic pv, input logic [3:0] d, input logic [63:0] dt,
                       input logic fr, input logic fv, input logic [33:0] fo,
                       input logic prdy, input logic bsy, input logic [15:0] cnt);
        vec_t v;
        v.mode = m; v.pv = pv; v.dest = d; v.data = dt; v.fr = fr;
        v.e_fv = fv; v.e_fo = fo; v.e_prdy = prdy; v.e_busy = bsy; v.e_cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Safety net in case anything stalls the sequence.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq_exp;
        reset = 1'b0; mode = 1'b0; pkt_valid = 1'b0; pkt_dest = 4'h0;
        pkt_data = 64'd0; flit_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        #1;
        chk("rst_flit_valid", 64'(flit_valid), 64'd0);
        chk("rst_flit_out", 64'(flit_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(pkt_sent_cnt), 64'd0);
        reset = 1'b1;

        // Test 1: basic packet
        add(0, 1, 4'h5, 64'h1111_2222_3333_4444, 1, 0, 34'h0,           1, 0, 16'd0);
        add(0, 0, 4'h0, 64'h0,                   1, 1, 34'h1_0205_0000, 0, 1, 16'd0);
        add(0, 0, 4'h0, 64'h0,                   1, 1, 34'h0_1111_2222, 0, 1, 16'd0);
        add(0, 0, 4'h0, 64'h0,                   1, 1, 34'h2_3333_4444, 0, 1, 16'd0);
        add(0, 0, 4'h0, 64'h0,                   1, 0, 34'h0,           1, 0, 16'd1);
        // Test 2: eject-phase pause after head, with input noise while paused
        add(0, 1, 4'hA, 64'hDEAD_BEEF_CAFE_F00D, 1, 0, 34'h0,           1, 0, 16'd1);
        add(0, 0, 4'h0, 64'h0,                   1, 1, 34'h1_020A_0000, 0, 1, 16'd1);
        for (int i = 0; i < 8; i++) begin
            add(1, 1, 4'hF, 64'h5555_6666_7777_8888, 1, 0, 34'h0, 0, 1, 16'd1);
        end
        add(0, 0, 4'h0, 64'h0,                   1, 1, 34'h0_DEAD_BEEF, 0, 1, 16'd1);
        add(1, 0, 4'h0, 64'h0,                   1, 0, 34'h0,           0, 1, 16'd1);
        add(0, 0, 4'h0, 64'h0,                   1, 1, 34'h2_CAFE_F00D, 0, 1, 16'd1);
        add(0, 0, 4'h0, 64'h0,                   1, 0, 34'h0,           1, 0, 16'd2);

        foreach (vecs[i]) begin
            tick();
            mode = vecs[i].mode; pkt_valid = vecs[i].pv; pkt_dest = vecs[i].dest;
            pkt_data = vecs[i].data; flit_ready = vecs[i].fr;
            #1;
            chk($sformatf("v%0d_flit_valid", i), 64'(flit_valid), 64'(vecs[i].e_fv));
            chk($sformatf("v%0d_pkt_ready", i), 64'(pkt_ready), 64'(vecs[i].e_prdy));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            chk($sformatf("v%0d_cnt", i), 64'(pkt_sent_cnt), 64'(vecs[i].e_cnt));
            if (vecs[i].e_fv) begin
                chk($sformatf("v%0d_flit_out", i), 64'(flit_out), 64'(vecs[i].e_fo));
            end
        end

        // Test 3: network back-pressure during BODY
        tick();
        pkt_valid = 1'b1; pkt_dest = 4'h3; pkt_data = 64'h0123_4567_89AB_CDEF; flit_ready = 1'b1;
        tick();
        pkt_valid = 1'b0;
        #1 chk("t3_head", 64'(flit_out), 64'(34'h1_0203_0000));
        tick();
        flit_ready = 1'b0; pkt_valid = 1'b1; pkt_data = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_stall_valid", 64'(flit_valid), 64'd1);
            chk("t3_stall_body", 64'(flit_out), 64'(34'h0_0123_4567));
            chk("t3_stall_ready", 64'(pkt_ready), 64'd0);
            tick();
        end
        flit_ready = 1'b1; pkt_valid = 1'b0;
        #1 chk("t3_body", 64'(flit_out), 64'(34'h0_0123_4567));
        tick();
        #1 chk("t3_tail", 64'(flit_out), 64'(34'h2_89AB_CDEF));
        tick();
        #1 chk("t3_cnt", 64'(pkt_sent_cnt), 64'd3);

        // Test 4: reset while in TAIL drops the packet
        pkt_valid = 1'b1; pkt_dest = 4'h7; pkt_data = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        pkt_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1 chk("t4_in_tail", 64'(flit_out), 64'(34'h2_CCCC_DDDD));
        tick();
        reset = 1'b1;
        #1;
        chk("t4_flit_valid", 64'(flit_valid), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_cnt", 64'(pkt_sent_cnt), 64'd0);
        chk("t4_pkt_ready", 64'(pkt_ready), 64'd1);
        chk("t4_flit_out", 64'(flit_out), 64'd0);

        // Test 6: pkt_valid held high, one packet every 4 cycles
        tick();
        pkt_valid = 1'b1; pkt_dest = 4'h1; pkt_data = 64'h0000_0001_0000_0002; flit_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("t6_valid_%0d", k), 64'(flit_valid), 64'((k % 4) != 0));
            chk($sformatf("t6_ready_%0d", k), 64'(pkt_ready), 64'((k % 4) == 0));
            tick();
        end
        pkt_valid = 1'b0;
        #1 chk("t6_cnt", 64'(pkt_sent_cnt), 64'd3);

        // Test 5: 257 packets, sequence field wraps after 8'hFF
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int p = 0; p < 257; p++) begin
            pkt_valid = 1'b1; pkt_dest = 4'(p); pkt_data = 64'(p);
            tick();
            pkt_valid = 1'b0;
`ifdef NI_PKT_SEQ_EN
            seq_exp = 8'(p);
`else
            seq_exp = 8'h00;
`endif
            #1 chk($sformatf("t5_head_%0d", p), 64'(flit_out),
                   64'({2'b01, 8'h02, 4'h0, 4'(p), seq_exp, 8'h00}));
            tick();
            tick();
            tick();
        end
        #1 chk("t5_cnt", 64'(pkt_sent_cnt), 64'd257);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
